// File: rtl/axi4_mem_responder.sv
// rtl/axi4_mem_responder.sv - AXI4 slave backed by an on-chip memory array
module axi4_mem_responder #(
    parameter int ID_W   = 16,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512,
    parameter int DEPTH  = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);
    localparam int BPB   = DATA_W / 8;
    localparam int OFF   = $clog2(BPB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_VALID} r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] aw_word;
    logic [ADDR_W-1:0] ar_word;
    assign aw_word = s_axi_awaddr >> OFF;
    assign ar_word = s_axi_araddr >> OFF;

    w_state_t         w_state;
    w_state_t         w_next;
    logic [ID_W-1:0]  w_id;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_len;
    logic             w_fixed;
    logic             w_oor;
    logic             w_err;
    logic [8:0]       w_cnt;
    logic             aw_hs;
    logic             w_hs;
    logic             w_commit;

    assign aw_hs    = s_axi_awvalid && s_axi_awready;
    assign w_hs     = s_axi_wvalid && s_axi_wready;
    assign w_commit = w_hs && !w_oor && (w_cnt <= {1'b0, w_len});

    always_comb begin
        w_next        = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && s_axi_wlast) w_next = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign s_axi_bid   = w_id;
    assign s_axi_bresp = (w_state == W_RESP &&
                          (w_cnt != {1'b0, w_len} + 9'd1 || w_oor || w_err))
                         ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_idx   <= '0;
            w_len   <= '0;
            w_fixed <= 1'b0;
            w_oor   <= 1'b0;
            w_err   <= 1'b0;
            w_cnt   <= '0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                w_id    <= s_axi_awid;
                w_idx   <= aw_word[IDX_W-1:0];
                w_len   <= s_axi_awlen;
                w_fixed <= (s_axi_awburst == 2'b00);
                w_oor   <= (aw_word >= ADDR_W'(DEPTH));
                w_err   <= s_axi_awburst[1];
                w_cnt   <= '0;
            end else if (w_hs) begin
                // Surplus beats park the counter at len+2 so it stays wrong without overflowing
                w_cnt <= (w_cnt > {1'b0, w_len}) ? {1'b0, w_len} + 9'd2 : w_cnt + 9'd1;
                if (!w_fixed) w_idx <= w_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < BPB; b++) begin
                if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    r_state_t          r_state;
    r_state_t          r_next;
    logic [ID_W-1:0]   r_id;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_len;
    logic [7:0]        r_beat;
    logic              r_fixed;
    logic              r_oor;
    logic [1:0]        r_resp;
    logic [DATA_W-1:0] r_data;
    logic              ar_hs;

    assign ar_hs = s_axi_arvalid && s_axi_arready;

    always_comb begin
        r_next        = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) r_next = R_FETCH;
            end
            R_FETCH: r_next = R_VALID;
            R_VALID: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) r_next = (r_beat == r_len) ? R_IDLE : R_FETCH;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign s_axi_rid   = r_id;
    assign s_axi_rdata = r_data;
    assign s_axi_rresp = r_resp;
    assign s_axi_rlast = (r_state == R_VALID) && (r_beat == r_len);

    // The fetch register reads the array with non-blocking semantics, so a
    // same-cycle write commit to the same word is seen only by later fetches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_fixed <= 1'b0;
            r_oor   <= 1'b0;
            r_resp  <= RESP_OKAY;
            r_data  <= '0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                r_id    <= s_axi_arid;
                r_idx   <= ar_word[IDX_W-1:0];
                r_len   <= s_axi_arlen;
                r_beat  <= '0;
                r_fixed <= (s_axi_arburst == 2'b00);
                r_oor   <= (ar_word >= ADDR_W'(DEPTH));
                r_resp  <= (ar_word >= ADDR_W'(DEPTH) || s_axi_arburst[1]) ? RESP_SLVERR : RESP_OKAY;
            end
            if (r_state == R_FETCH) r_data <= r_oor ? '0 : mem[r_idx];
            if (r_state == R_VALID && s_axi_rready && r_beat != r_len) begin
                r_beat <= r_beat + 8'd1;
                if (!r_fixed) r_idx <= r_idx + 1'b1;
            end
        end
    end
endmodule
